// File: rtl/sprite_word_decoder.sv
// sprite_word_decoder: filters the free-running sprite command word, range-checks
// the coordinates and commits accepted words to the drawing registers on the
// next frame boundary so a sprite never moves mid-frame.
// Optional build macro SPRITE_DECODER_CLAMP_EN: out-of-range coordinates are
// clamped to the nearest legal bound and the word is still committed.
//
// state      | meaning
// IDLE       | waiting for the sampled word to differ from the last accepted one
// TRACK      | counting consecutive identical samples of the candidate word
// CHECK      | one-cycle range check of the stable candidate
// WAIT_FRAME | accepted word held in pend_q until new_frame
module sprite_word_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int X_MIN         = 1,
  parameter int X_MAX         = 620,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = 460
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        new_frame,
  output logic [2:0]  sprite_flags,
  output logic [9:0]  sprite_x,
  output logic [9:0]  sprite_y,
  output logic [8:0]  sprite_offset,
  output logic        update,
  output logic        pending,
  output logic        err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, TRACK, CHECK, WAIT_FRAME} state_t;

  localparam logic [3:0] STABLE_V = 4'(STABLE_CYCLES);
  localparam logic [9:0] X_MIN_V  = 10'(X_MIN);
  localparam logic [9:0] X_MAX_V  = 10'(X_MAX);
  localparam logic [9:0] Y_MIN_V  = 10'(Y_MIN);
  localparam logic [9:0] Y_MAX_V  = 10'(Y_MAX);

`ifdef SPRITE_DECODER_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  state_t      state, state_n;
  logic [31:0] in_q, cand, last_acc, pend_q, cand_commit;
  logic [3:0]  cnt;
  logic        load_cand, inc_cnt, accept, reject, commit;
  logic        x_lo_ok, x_hi_ok, y_lo_ok, y_hi_ok, in_range;

  // a >= b via an 11-bit borrow, so a zero bound does not become a constant compare
  function automatic logic ge10(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] d;
    d = {1'b0, a} - {1'b0, b};
    return ~d[10];
  endfunction

  assign x_lo_ok  = ge10(cand[28:19], X_MIN_V);
  assign x_hi_ok  = ge10(X_MAX_V, cand[28:19]);
  assign y_lo_ok  = ge10(cand[18:9], Y_MIN_V);
  assign y_hi_ok  = ge10(Y_MAX_V, cand[18:9]);
  assign in_range = x_lo_ok && x_hi_ok && y_lo_ok && y_hi_ok;

`ifdef SPRITE_DECODER_CLAMP_EN
  logic [9:0] x_cl, y_cl;
  assign x_cl = !x_lo_ok ? X_MIN_V : (!x_hi_ok ? X_MAX_V : cand[28:19]);
  assign y_cl = !y_lo_ok ? Y_MIN_V : (!y_hi_ok ? Y_MAX_V : cand[18:9]);
  assign cand_commit = {cand[31:29], x_cl, y_cl, cand[8:0]};
`else
  assign cand_commit = cand;
`endif

  assign pending = (state == WAIT_FRAME);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next state and datapath strobes; the IDLE->TRACK edge already counts as the
  // first stable sample, so CHECK follows STABLE_CYCLES samples after a change
  always_comb begin
    state_n   = state;
    load_cand = 1'b0;
    inc_cnt   = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (in_q != last_acc) begin
          load_cand = 1'b1;
          state_n   = (STABLE_CYCLES == 1) ? CHECK : TRACK;
        end
      end
      TRACK: begin
        if (in_q != cand)                     load_cand = 1'b1;
        else if (cnt + 4'd1 == STABLE_V)      state_n   = CHECK;
        else                                  inc_cnt   = 1'b1;
      end
      CHECK: begin
        if (cand == last_acc) begin
          state_n = IDLE;
        end else begin
          reject = !in_range;
          if (in_range || CLAMP_ON) begin
            accept  = 1'b1;
            state_n = WAIT_FRAME;
          end else begin
            state_n = IDLE;
          end
        end
      end
      WAIT_FRAME: begin
        if (new_frame) begin
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // sampling, candidate tracking, error counting and frame-boundary commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q          <= '0;
      cand          <= '0;
      last_acc      <= '0;
      pend_q        <= '0;
      cnt           <= '0;
      err           <= 1'b0;
      err_count     <= '0;
      update        <= 1'b0;
      sprite_flags  <= '0;
      sprite_x      <= '0;
      sprite_y      <= '0;
      sprite_offset <= '0;
    end else begin
      in_q <= data_in;
      if (load_cand) begin
        cand <= in_q;
        cnt  <= 4'd1;
      end else if (inc_cnt) begin
        cnt <= cnt + 4'd1;
      end
      if (accept)          pend_q   <= cand_commit;
      if (accept || reject) last_acc <= cand;
      err <= reject;
      if (reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
      update <= commit;
      if (commit) begin
        sprite_flags  <= pend_q[31:29];
        sprite_x      <= pend_q[28:19];
        sprite_y      <= pend_q[18:9];
        sprite_offset <= pend_q[8:0];
      end
    end
  end

endmodule
